// File: rtl/ysyx_22050039_core_ctrl_pkg.sv
// Shared encodings for the core sequencer: FSM states, decoder func codes
// and trap causes.
package ysyx_22050039_core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] FUNC_ADDI   = 3'd0;
  localparam logic [2:0] FUNC_JALR   = 3'd1;
  localparam logic [2:0] FUNC_AUIPC  = 3'd2;
  localparam logic [2:0] FUNC_LUI    = 3'd3;
  localparam logic [2:0] FUNC_SD     = 3'd4;
  localparam logic [2:0] FUNC_JAL    = 3'd5;
  localparam logic [2:0] FUNC_EBREAK = 3'd6;
  localparam logic [2:0] FUNC_INV    = 3'd7;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_INV    = 2'd1;
  localparam logic [1:0] CAUSE_IF_TO  = 2'd2;
  localparam logic [1:0] CAUSE_MEM_TO = 2'd3;

  // States that wait on a bus ack and are therefore guarded by the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/ysyx_22050039_core_ctrl_if.sv
// Fetch/memory/decoder/status bundle between the sequencer (master) and the
// rest of the core (slave).
interface ysyx_22050039_core_ctrl_if #(
  parameter int XLEN = 64
) ();
  logic            if_req;
  logic            if_ack;
  logic            inst_en;
  logic [2:0]      func;
  logic            dec_pc_wen;
  logic            mem_req;
  logic            mem_wen;
  logic            mem_ack;
  logic            reg_wen;
  logic            pc_wen;
  logic            pc_sel;
  logic            halt;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [XLEN-1:0] instret;

  modport master (
    output if_req, inst_en, mem_req, mem_wen, reg_wen, pc_wen, pc_sel,
           halt, trap, trap_cause, instret,
    input  if_ack, func, dec_pc_wen, mem_ack
  );

  modport slave (
    input  if_req, inst_en, mem_req, mem_wen, reg_wen, pc_wen, pc_sel,
           halt, trap, trap_cause, instret,
    output if_ack, func, dec_pc_wen, mem_ack
  );
endinterface

// File: rtl/ysyx_22050039_timeout_cnt.sv
// Clearable wait counter; expired fires on the TIMEOUT-th consecutive
// enabled cycle without an ack.
module ysyx_22050039_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_ack,
  output logic o_expired
);
  logic [TO_W-1:0] r_cnt;

  assign o_expired = i_en && !i_ack && (r_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !i_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ysyx_22050039_core_ctrl.sv
// Multi-cycle sequencer: fetch handshake, decode latch, store handshake,
// writeback strobes, retire counting and halt/trap stop states.
module ysyx_22050039_core_ctrl
  import ysyx_22050039_core_ctrl_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  ysyx_22050039_core_ctrl_if.master         bus
);
  state_t          r_state, w_state_next;
  logic [2:0]      r_func;
  logic            r_pc_wen;
  logic [1:0]      r_cause, w_cause_next;
  logic [XLEN-1:0] r_instret;
  logic            w_to_en, w_to_ack, w_to_clr, w_expired;

  assign w_to_en  = is_wait_state(r_state);
  assign w_to_ack = (r_state == ST_FETCH) ? bus.if_ack : bus.mem_ack;
  assign w_to_clr = is_wait_state(w_state_next) && (w_state_next != r_state);

  ysyx_22050039_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_to_clr),
    .i_en      (w_to_en),
    .i_ack     (w_to_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_func    <= '0;
      r_pc_wen  <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_func   <= bus.func;
        r_pc_wen <= bus.dec_pc_wen;
      end
      if ((w_state_next == ST_TRAP) && (r_state != ST_TRAP)) begin
        r_cause <= w_cause_next;
      end
      if (r_state == ST_WB) begin
        r_instret <= r_instret + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cause_next   = CAUSE_NONE;
    bus.if_req     = 1'b0;
    bus.inst_en    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.reg_wen    = 1'b0;
    bus.pc_wen     = 1'b0;
    bus.pc_sel     = 1'b0;
    bus.halt       = 1'b0;
    bus.trap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        bus.if_req = 1'b1;
        // An ack on the expiry cycle still wins over the timeout.
        if (bus.if_ack) begin
          bus.inst_en  = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_expired) begin
          w_state_next = ST_TRAP;
          w_cause_next = CAUSE_IF_TO;
        end
      end
      ST_DECODE: begin
        if (bus.func == FUNC_EBREAK) begin
          w_state_next = ST_HALT;
        end else if (bus.func == FUNC_INV) begin
          w_state_next = ST_TRAP;
          w_cause_next = CAUSE_INV;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_next = (r_func == FUNC_SD) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_wen = 1'b1;
        if (bus.mem_ack) begin
          w_state_next = ST_WB;
        end else if (w_expired) begin
          w_state_next = ST_TRAP;
          w_cause_next = CAUSE_MEM_TO;
        end
      end
      ST_WB: begin
        bus.pc_wen   = 1'b1;
        bus.pc_sel   = r_pc_wen;
        bus.reg_wen  = (r_func != FUNC_SD);
        w_state_next = ST_FETCH;
      end
      ST_HALT: bus.halt = 1'b1;
      ST_TRAP: bus.trap = 1'b1;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.trap_cause = (r_state == ST_TRAP) ? r_cause : CAUSE_NONE;
  assign bus.instret    = r_instret;
endmodule

// File: tb/tb_ysyx_22050039_core_ctrl.sv
// Scoreboard bench: stimulus queues expected retire/halt/trap events, a
// negedge monitor pops and compares them as the sequencer presents them.
module tb_ysyx_22050039_core_ctrl;
  localparam int XLEN = 64;

  typedef struct {
    int          kind;      // 0 retire, 1 halt, 2 trap
    logic        pc_sel;
    logic        reg_wen;
    logic [1:0]  cause;
    logic [63:0] instret;
    int          if_cyc;
    int          mem_cyc;
    int          inst_cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050039_core_ctrl_if #(.XLEN(XLEN)) bus ();

  ysyx_22050039_core_ctrl #(
    .XLEN    (XLEN),
    .TIMEOUT (16),
    .TO_W    (5)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus)
  );

  ev_t         exp_q[$];
  int          n_total = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [63:0] im = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: counts handshake cycles between events and checks each event.
  int   c_if = 0, c_mem = 0, c_inst = 0, kind;
  logic halt_prev = 1'b0, trap_prev = 1'b0;
  ev_t  e_mon;
  always @(negedge clk) begin
    if (rst) begin
      c_if = 0; c_mem = 0; c_inst = 0; halt_prev = 1'b0; trap_prev = 1'b0;
    end else begin
      if (bus.if_req)  c_if++;
      if (bus.mem_req) c_mem++;
      if (bus.inst_en) c_inst++;
      if (bus.pc_wen || (bus.halt && !halt_prev) || (bus.trap && !trap_prev)) begin
        kind = bus.pc_wen ? 0 : (bus.halt ? 1 : 2);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
          e_mon = exp_q.pop_front();
          $display("event kind=%0d instret=%0d if_cyc=%0d mem_cyc=%0d", kind, bus.instret, c_if, c_mem);
          chk("ev_kind", kind, e_mon.kind);
          chk("ev_pc_sel", bus.pc_sel, e_mon.pc_sel);
          chk("ev_reg_wen", bus.reg_wen, e_mon.reg_wen);
          chk("ev_cause", bus.trap_cause, e_mon.cause);
          chk("ev_instret", bus.instret, e_mon.instret);
          chk("ev_if_cycles", c_if, e_mon.if_cyc);
          chk("ev_mem_cycles", c_mem, e_mon.mem_cyc);
          chk("ev_inst_en", c_inst, e_mon.inst_cyc);
        end
        c_if = 0; c_mem = 0; c_inst = 0;
      end
      halt_prev = bus.halt;
      trap_prev = bus.trap;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    bus.if_ack = 1'b0; bus.mem_ack = 1'b0; bus.func = 3'd0; bus.dec_pc_wen = 1'b0;
    tick(); tick();
    rst = 1'b0;
    im = 0;
  endtask

  task automatic start_core();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called with the sequencer in its first FETCH cycle; returns in the next
  // FETCH (retire) or in HALT/TRAP.
  task automatic run_inst(input int f, input logic p, input int fw, input int mw);
    ev_t e;
    e.kind     = (f == 6) ? 1 : ((f == 7) ? 2 : 0);
    e.pc_sel   = (e.kind == 0) ? p : 1'b0;
    e.reg_wen  = (e.kind == 0) && (f != 4);
    e.cause    = (f == 7) ? 2'd1 : 2'd0;
    e.instret  = im;
    e.if_cyc   = fw + 1;
    e.mem_cyc  = (f == 4) ? mw + 1 : 0;
    e.inst_cyc = 1;
    exp_q.push_back(e);
    if (e.kind == 0) im++;
    bus.func = 3'(f); bus.dec_pc_wen = p;
    bus.if_ack = 1'b0;
    repeat (fw) tick();
    bus.if_ack = 1'b1;
    tick();
    bus.if_ack = 1'b0;
    tick();
    if (e.kind != 0) return;
    if (f == 4) begin
      tick();
      repeat (mw) tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
    end else begin
      tick();
    end
    tick();
  endtask

  int  t0;
  ev_t e;
  initial begin
    do_reset();
    chk("rst_if_req", bus.if_req, 0);
    chk("rst_reg_wen", bus.reg_wen, 0);
    chk("rst_pc_wen", bus.pc_wen, 0);
    chk("rst_halt", bus.halt, 0);
    chk("rst_trap", bus.trap, 0);
    chk("rst_instret", bus.instret, 0);

    // addi stream with zero-wait acks, then sd, jal, slow sd, ebreak
    start_core();
    t0 = cyc;
    repeat (3) run_inst(0, 1'b0, 0, 0);
    chk("t1_cycles", cyc - t0, 12);
    chk("t1_instret", bus.instret, 3);
    t0 = cyc;
    run_inst(4, 1'b0, 0, 2);
    chk("t2_cycles", cyc - t0, 7);
    chk("t2_instret", bus.instret, 4);
    run_inst(5, 1'b1, 0, 0);
    chk("t3_refetch", bus.if_req, 1);
    run_inst(4, 1'b0, 0, 15);
    chk("t3_sd_slow_instret", bus.instret, 6);
    run_inst(6, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      start = 1'(i % 2);
      bus.if_ack = 1'((i + 1) % 2);
      tick();
      chk("t4_halt_held", bus.halt, 1);
      chk("t4_if_req_low", bus.if_req, 0);
    end
    chk("t4_instret", bus.instret, 6);

    // fetch timeout
    do_reset();
    start_core();
    e = '{kind: 2, pc_sel: 1'b0, reg_wen: 1'b0, cause: 2'd2, instret: 64'd0,
          if_cyc: 16, mem_cyc: 0, inst_cyc: 0};
    exp_q.push_back(e);
    repeat (20) tick();
    chk("t5_fetch_to_cause", bus.trap_cause, 2);

    // ack on the last allowed fetch cycle, then invalid instruction
    do_reset();
    start_core();
    run_inst(0, 1'b0, 15, 0);
    run_inst(7, 1'b0, 0, 0);
    repeat (3) tick();
    chk("t5_inv_cause", bus.trap_cause, 1);

    // memory timeout
    do_reset();
    start_core();
    e = '{kind: 2, pc_sel: 1'b0, reg_wen: 1'b0, cause: 2'd3, instret: 64'd0,
          if_cyc: 1, mem_cyc: 16, inst_cyc: 1};
    exp_q.push_back(e);
    bus.func = 3'd4;
    bus.if_ack = 1'b1;
    tick();
    bus.if_ack = 1'b0;
    repeat (20) tick();
    chk("t5_mem_to_cause", bus.trap_cause, 3);

    // reset in the middle of a store handshake
    do_reset();
    start_core();
    run_inst(0, 1'b0, 0, 0);
    bus.func = 3'd4;
    bus.if_ack = 1'b1;
    tick();
    bus.if_ack = 1'b0;
    tick();
    tick();
    chk("t6_mem_req_before", bus.mem_req, 1);
    rst = 1'b1;
    #1;
    chk("t6_mem_req_async", bus.mem_req, 0);
    chk("t6_instret_cleared", bus.instret, 0);
    tick();
    rst = 1'b0;
    im = 0;
    repeat (3) tick();
    chk("t6_idle_after_rst", bus.if_req, 0);
    start_core();
    chk("t6_resume_fetch", bus.if_req, 1);

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
